// File: rtl/array_mult_arbiter_if.sv
// Requester/multiplier-bank bundle for array_mult_arbiter.
// Optional busy_cycles signal is present only when ARRAY_MULT_ARB_STATS_EN is defined.
interface array_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LANES   = 9,
    parameter int WIDTH   = 27
);
    // Handshake: an operation is accepted in any cycle where req[i] & gnt[i];
    // gnt is combinational and there is no backpressure after acceptance.
    logic                                     en;
    logic [NUM_REQ-1:0]                       req;
    logic [NUM_REQ-1:0]                       req_lock;
    logic [NUM_REQ-1:0][LANES-1:0][WIDTH-1:0] req_dataa;
    logic [NUM_REQ-1:0][LANES-1:0][WIDTH-1:0] req_datab;
    logic [NUM_REQ-1:0]                       gnt;
    logic [LANES-1:0][WIDTH-1:0]              array_mult_dataa;
    logic [LANES-1:0][WIDTH-1:0]              array_mult_datab;
    logic [LANES-1:0][WIDTH-1:0]              array_mult_result;
    logic [LANES-1:0][WIDTH-1:0]              result;
    logic [NUM_REQ-1:0]                       result_valid;
`ifdef ARRAY_MULT_ARB_STATS_EN
    logic [31:0]                              busy_cycles;
`endif

    modport master (
        output en, req, req_lock, req_dataa, req_datab, array_mult_result,
        input  gnt, array_mult_dataa, array_mult_datab, result, result_valid
`ifdef ARRAY_MULT_ARB_STATS_EN
        , input busy_cycles
`endif
    );

    modport slave (
        input  en, req, req_lock, req_dataa, req_datab, array_mult_result,
        output gnt, array_mult_dataa, array_mult_datab, result, result_valid
`ifdef ARRAY_MULT_ARB_STATS_EN
        , output busy_cycles
`endif
    );
endinterface

// File: rtl/array_mult_arbiter.sv
// Round-robin arbiter with lock/burst that shares one multiplier bank and tags results back.
// Define ARRAY_MULT_ARB_STATS_EN to add the saturating busy_cycles accept counter.
module array_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LANES        = 9,
    parameter int WIDTH        = 27,
    parameter int MULT_LATENCY = 3,
    parameter int MAX_BURST    = 4
) (
    input logic               clk,
    input logic               rst,
    array_mult_arbiter_if.slave bus
);
    localparam int IDXW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STAGES = MULT_LATENCY + 1;

    logic [IDXW-1:0]             ptr_q, ptr_d;
    logic [3:0]                  burst_q, burst_d;
    logic [IDXW-1:0]             win;
    logic [IDXW-1:0]             cand;
    logic                        found;
    logic                        accept;
    logic [4:0]                  burst_inc;
    logic [LANES-1:0][WIDTH-1:0] opa_q, opb_q;
    logic [STAGES-1:0]           tag_vld_q;
    logic [STAGES-1:0][2:0]      tag_idx_q;

    // First requesting index at or after the priority pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDXW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign accept  = found & bus.en & ~rst;
    assign bus.gnt = accept ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        // A locked winner that was not the pointer owner starts a fresh burst.
        burst_inc = ((win == ptr_q) ? {1'b0, burst_q} : 5'd0) + 5'd1;
        if (accept) begin
            if (bus.req_lock[win] && (burst_inc < 5'(MAX_BURST))) begin
                ptr_d   = win;
                burst_d = burst_inc[3:0];
            end else begin
                ptr_d   = (win == IDXW'(NUM_REQ - 1)) ? '0 : win + IDXW'(1);
                burst_d = '0;
            end
        end else if (!bus.req_lock[ptr_q]) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            burst_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            if (accept) begin
                opa_q <= bus.req_dataa[win];
                opb_q <= bus.req_datab[win];
            end
        end
    end

    // Tag pipeline runs regardless of en so accepted work always drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_q <= '0;
            tag_idx_q <= '0;
        end else begin
            tag_vld_q[0] <= accept;
            tag_idx_q[0] <= 3'(win);
            for (int k = 1; k < STAGES; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    assign bus.array_mult_dataa = opa_q;
    assign bus.array_mult_datab = opb_q;
    assign bus.result           = bus.array_mult_result;
    assign bus.result_valid     = tag_vld_q[STAGES-1] ?
                                  (NUM_REQ'(1) << tag_idx_q[STAGES-1]) : '0;

`ifdef ARRAY_MULT_ARB_STATS_EN
    logic [31:0] busy_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else if (accept && (busy_q != '1)) begin
            busy_q <= busy_q + 32'd1;
        end
    end
    assign bus.busy_cycles = busy_q;
`endif
endmodule

// File: tb/tb_array_mult_arbiter.sv
// Self-checking bench for array_mult_arbiter: grant table, model multiplier, result scoreboard.
module tb_array_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LANES   = 9;
    localparam int WIDTH   = 27;
    localparam int LAT     = 3;
    localparam int MB      = 4;
    localparam int W       = 73;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       en;
        logic [3:0] gnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    logic mon_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_bank_a = '0;
    logic [WIDTH-1:0] exp_bank_b = '0;
    vec_t tbl[$];
    logic [LANES-1:0][WIDTH-1:0] m_s [LAT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    array_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .LANES(LANES), .WIDTH(WIDTH)) bus ();

    array_mult_arbiter #(
        .NUM_REQ(NUM_REQ), .LANES(LANES), .WIDTH(WIDTH),
        .MULT_LATENCY(LAT), .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [WIDTH-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] f;
        f = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return f[WIDTH-1:0];
    endfunction

    // Model multiplier bank: product of the bank inputs LAT cycles later.
    always @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            m_s[0][l] <= mul(bus.array_mult_dataa[l], bus.array_mult_datab[l]);
        for (int k = 1; k < LAT; k++)
            m_s[k] <= m_s[k-1];
    end
    assign bus.array_mult_result = m_s[LAT-1];

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    endfunction

    function automatic void add(input logic [3:0] r, input logic [3:0] l, input logic e, input logic [3:0] g);
        vec_t v;
        v.req = r; v.lock = l; v.en = e; v.gnt = g;
        tbl.push_back(v);
    endfunction

    // Scoreboard consumer: every cycle either an expected result or silence.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en) begin
            if (exp_q.size() > 0 && int'(exp_q[0][72:57]) == cyc) begin
                e = exp_q.pop_front();
                chk("result_valid", 64'(bus.result_valid), 64'(4'(1) << e[56:54]));
                chk("result_lane0", 64'(bus.result[0]), 64'(e[53:27]));
                chk("result_lane8", 64'(bus.result[8]), 64'(e[26:0]));
            end else begin
                chk("result_valid_idle", 64'(bus.result_valid), 64'(0));
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic e);
        bus.en       = e;
        bus.req      = r;
        bus.req_lock = l;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < LANES; j++) begin
                bus.req_dataa[i][j] = WIDTH'($urandom);
                bus.req_datab[i][j] = WIDTH'($urandom);
            end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic e, input logic [3:0] g);
        int idx;
        @(posedge clk);
        #1;
        chk("bank_a_lane0", 64'(bus.array_mult_dataa[0]), 64'(exp_bank_a));
        chk("bank_b_lane8", 64'(bus.array_mult_datab[8]), 64'(exp_bank_b));
        drive(r, l, e);
        #1;
        chk("gnt", 64'(bus.gnt), 64'(g));
        if (g != 4'b0) begin
            idx = 0;
            for (int i = 0; i < NUM_REQ; i++) if (g[i]) idx = i;
            exp_bank_a = bus.req_dataa[idx][0];
            exp_bank_b = bus.req_datab[idx][8];
            exp_q.push_back({16'(cyc + 1 + LAT), 3'(idx),
                             mul(bus.req_dataa[idx][0], bus.req_datab[idx][0]),
                             mul(bus.req_dataa[idx][8], bus.req_datab[idx][8])});
            n_acc++;
        end
    endtask

    initial begin
        // Single accept, then idle so its result lands alone.
        add(4'b0001, 4'b0000, 1'b1, 4'b0001);
        for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 1'b1, 4'b0000);
        // All requesting, no lock: rotation starting after requester 0.
        add(4'b1111, 4'b0000, 1'b1, 4'b0010);
        add(4'b1111, 4'b0000, 1'b1, 4'b0100);
        add(4'b1111, 4'b0000, 1'b1, 4'b1000);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001);
        add(4'b1111, 4'b0000, 1'b1, 4'b0010);
        add(4'b1111, 4'b0000, 1'b1, 4'b0100);
        add(4'b1111, 4'b0000, 1'b1, 4'b1000);
        // Locked burst of MAX_BURST, forced rotation, then requester 0 again.
        for (int i = 0; i < MB; i++) add(4'b0011, 4'b0001, 1'b1, 4'b0001);
        add(4'b0011, 4'b0001, 1'b1, 4'b0010);
        add(4'b0011, 4'b0001, 1'b1, 4'b0001);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(4'b1111, 4'b0000, 1'b0, 4'b0000);
        add(4'b0100, 4'b0000, 1'b1, 4'b0100);
        add(4'b1001, 4'b0000, 1'b1, 4'b1000);
        add(4'b1001, 4'b0000, 1'b1, 4'b0001);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000);
        add(4'b0011, 4'b0000, 1'b1, 4'b0010);
        // Three back-to-back accepts, then en low while still requesting.
        add(4'b1111, 4'b0000, 1'b1, 4'b0100);
        add(4'b1111, 4'b0000, 1'b1, 4'b1000);
        add(4'b1111, 4'b0000, 1'b1, 4'b0001);
        add(4'b1111, 4'b0000, 1'b0, 4'b0000);
        add(4'b1111, 4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 6; i++) add(4'b0000, 4'b0000, 1'b1, 4'b0000);

        rst = 1'b1;
        drive(4'b1111, 4'b0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_bank_a", 64'(bus.array_mult_dataa[0]), 64'(0));
        chk("rst_result_valid", 64'(bus.result_valid), 64'(0));
        drive(4'b0000, 4'b0000, 1'b1);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].req, tbl[i].lock, tbl[i].en, tbl[i].gnt);

        // Reset two cycles after an accept discards its tag.
        step(4'b0010, 4'b0000, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        @(posedge clk);
        #1;
        drive(4'b1111, 4'b0000, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 64'(bus.gnt), 64'(0));
        chk("midrst_bank_a", 64'(bus.array_mult_dataa[0]), 64'(0));
        chk("midrst_bank_b", 64'(bus.array_mult_datab[8]), 64'(0));
        chk("midrst_result_valid", 64'(bus.result_valid), 64'(0));
        exp_q.delete();
        exp_bank_a = '0;
        exp_bank_b = '0;
        n_acc = 0;
        @(posedge clk);
        #1;
        drive(4'b0000, 4'b0000, 1'b1);
        rst = 1'b0;
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);

        // Sparse accepts for the optional activity counter.
        for (int i = 0; i < 10; i++) begin
            step(4'b0001, 4'b0000, 1'b1, 4'b0001);
            step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        end
        for (int i = 0; i < 6; i++) step(4'b0000, 4'b0000, 1'b1, 4'b0000);

`ifdef ARRAY_MULT_ARB_STATS_EN
        chk("busy_cycles", 64'(bus.busy_cycles), 64'(n_acc));
`endif
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
